// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: multiplier with a fixed MUL_LAT-cycle wait and a
// radix-2 restoring divider, with RISC-V divide-by-zero and overflow results.
module muldiv_unit #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] MUL_LAST = XLEN'(MUL_LAT - 1);
   localparam logic [XLEN-1:0] DIV_LAST = XLEN'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t              r_state;
   logic                r_ready;
   logic                r_busy;
   logic                r_valid;
   logic [XLEN-1:0]     r_result;
   logic [1:0]          r_op;
   logic [XLEN-1:0]     r_a;
   logic [XLEN-1:0]     r_b;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_div;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [XLEN-1:0]     r_cnt;

   state_t              w_state_nxt;
   logic                w_load_result;
   logic [XLEN-1:0]     w_result_nxt;
   logic                w_accept;
   logic                w_a_sgn;
   logic                w_b_sgn;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic                w_b_zero;
   logic                w_ovf;
   logic [XLEN-1:0]     w_spec_res;
   logic [2*XLEN-1:0]   w_a_ext;
   logic [2*XLEN-1:0]   w_b_ext;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_mul_res;
   logic [XLEN:0]       w_trial;
   logic                w_ge;
   logic [2*XLEN-1:0]   w_acc_step;
   logic [XLEN-1:0]     w_q;
   logic [XLEN-1:0]     w_r;
   logic [XLEN-1:0]     w_fix_res;

   assign ready_o  = r_ready;
   assign busy_o   = r_busy;
   assign valid_o  = r_valid;
   assign result_o = r_result;

   // Operand conditioning at accept; funct3[0]=0 marks the signed divide ops
   assign w_accept   = (r_state == S_IDLE || r_state == S_DONE) && start_i && !flush_i;
   assign w_a_sgn    = ~funct3_i[0] & op_a_i[XLEN-1];
   assign w_b_sgn    = ~funct3_i[0] & op_b_i[XLEN-1];
   assign w_a_mag    = w_a_sgn ? -op_a_i : op_a_i;
   assign w_b_mag    = w_b_sgn ? -op_b_i : op_b_i;
   assign w_b_zero   = (op_b_i == '0);
   assign w_ovf      = ~funct3_i[0] && (op_a_i == MIN_NEG) && (&op_b_i);
   assign w_spec_res = funct3_i[1] ? (w_b_zero ? op_a_i : '0)
                                   : (w_b_zero ? '1 : op_a_i);

   // Sign/zero-extend to 2*XLEN so one unsigned multiply covers all four variants
   assign w_a_ext   = {{XLEN{r_a[XLEN-1] & (r_op == 2'b01 || r_op == 2'b10)}}, r_a};
   assign w_b_ext   = {{XLEN{r_b[XLEN-1] & (r_op == 2'b01)}}, r_b};
   assign w_prod    = w_a_ext * w_b_ext;
   assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   // Restoring step on {remainder, quotient}: trial-subtract the shifted remainder
   assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_div};
   assign w_ge       = ~w_trial[XLEN];
   assign w_acc_step = {w_ge ? w_trial[XLEN-1:0] : r_acc[2*XLEN-2:XLEN-1],
                        r_acc[XLEN-2:0], w_ge};

   assign w_q       = r_acc[XLEN-1:0];
   assign w_r       = r_acc[2*XLEN-1:XLEN];
   assign w_fix_res = r_op[1] ? (r_neg_r ? -w_r : w_r) : (r_neg_q ? -w_q : w_q);

   // Next-state and result-load decode
   always_comb begin
      w_state_nxt   = r_state;
      w_load_result = 1'b0;
      w_result_nxt  = r_result;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_nxt = S_IDLE;
            if (start_i) begin
               if (!funct3_i[2]) begin
                  w_state_nxt = S_MUL;
               end else if (w_b_zero || w_ovf) begin
                  w_state_nxt   = S_DONE;
                  w_load_result = 1'b1;
                  w_result_nxt  = w_spec_res;
               end else begin
                  w_state_nxt = S_DIV;
               end
            end
         end
         S_MUL: begin
            if (r_cnt == MUL_LAST) begin
               w_state_nxt   = S_DONE;
               w_load_result = 1'b1;
               w_result_nxt  = w_mul_res;
            end
         end
         S_DIV: begin
            if (r_cnt == DIV_LAST) w_state_nxt = S_FIX;
         end
         S_FIX: begin
            w_state_nxt   = S_DONE;
            w_load_result = 1'b1;
            w_result_nxt  = w_fix_res;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush_i) begin
         w_state_nxt   = S_IDLE;
         w_load_result = 1'b0;
      end
   end

   // State, registered status outputs and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_div    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
         r_busy  <= (w_state_nxt == S_MUL) || (w_state_nxt == S_DIV) || (w_state_nxt == S_FIX);
         r_valid <= (w_state_nxt == S_DONE);
         if (w_load_result) r_result <= w_result_nxt;
         if (w_accept) begin
            r_op    <= funct3_i[1:0];
            r_a     <= op_a_i;
            r_b     <= op_b_i;
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            r_div   <= w_b_mag;
            r_neg_q <= w_a_sgn ^ w_b_sgn;
            r_neg_r <= w_a_sgn;
            r_cnt   <= '0;
         end else begin
            if (r_state == S_MUL || r_state == S_DIV) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_DIV) r_acc <= w_acc_step;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, MUL_LAT=2).
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        ready;
   logic        busy;
   logic        valid;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.XLEN(32), .MUL_LAT(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start),
      .funct3_i (funct3),
      .op_a_i   (op_a),
      .op_b_i   (op_b),
      .flush_i  (flush),
      .ready_o  (ready),
      .busy_o   (busy),
      .valid_o  (valid),
      .result_o (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op (caller sits before a rising edge); report cycle of first valid, or -1
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
      funct3 = f3; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      lat = -1;
      res = 32'hxxxxxxxx;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            lat = n;
            res = result;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready, busy, valid} !== 3'b100) begin
         errors++; $display("FAIL reset_flags: got rdy/busy/vld=%b want 100", {ready, busy, valid});
      end
      checks++;
      if (result !== 32'h0) begin
         errors++; $display("FAIL reset_result: got %h want 00000000", result);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul;
      logic [3:0] vh, bh;
      funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFFFFFD; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op_a = 32'h12345678; op_b = 32'h9ABCDEF0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vh[k] = valid;
         bh[k] = busy;
      end
      checks++;
      if (vh !== 4'b0100) begin
         errors++; $display("FAIL mul_valid_cycles: got %b want 0100 (cycle4..1)", vh);
      end
      checks++;
      if (bh !== 4'b0011) begin
         errors++; $display("FAIL mul_busy_cycles: got %b want 0011 (cycle4..1)", bh);
      end
      checks++;
      if (result !== 32'hFFFFFFEB) begin
         errors++; $display("FAIL mul_result: got %h want ffffffeb", result);
      end
   endtask

   task automatic test_mulh;
      logic [2:0]  f3s  [3] = '{3'b001, 3'b011, 3'b010};
      logic [31:0] exps [3] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
      int          lat;
      logic [31:0] res;
      for (int i = 0; i < 3; i++) begin
         run_op(f3s[i], 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
         checks++;
         if (lat != 3) begin
            errors++; $display("FAIL mulh_lat[%0d]: got %0d want 3", i, lat);
         end
         checks++;
         if (res !== exps[i]) begin
            errors++; $display("FAIL mulh_result[%0d]: got %h want %h", i, res, exps[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_div;
      logic [2:0]  f3s [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] as  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd20, 32'd20,
                               32'h80000000, 32'h80000000};
      logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] exs [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFA, 32'd2,
                               32'h00000000, 32'h80000000};
      int          lat;
      logic [31:0] res;
      for (int i = 0; i < 8; i++) begin
         run_op(f3s[i], as[i], bs[i], lat, res);
         checks++;
         if (lat != 34) begin
            errors++; $display("FAIL div_lat[%0d]: got %0d want 34", i, lat);
         end
         checks++;
         if (res !== exs[i]) begin
            errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, exs[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_special;
      logic [2:0]  f3s [6] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100, 3'b111};
      logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
      logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
      logic [31:0] exs [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};
      int          lat;
      logic [31:0] res;
      for (int i = 0; i < 6; i++) begin
         run_op(f3s[i], as[i], bs[i], lat, res);
         checks++;
         if (lat != 1) begin
            errors++; $display("FAIL special_lat[%0d]: got %0d want 1", i, lat);
         end
         checks++;
         if (res !== exs[i]) begin
            errors++; $display("FAIL special_result[%0d]: got %h want %h", i, res, exs[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_flush;
      int          lat;
      logic [31:0] res;
      logic        seen;
      run_op(3'b000, 32'd9, 32'd9, lat, res);
      @(negedge clk);
      funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if ({ready, busy, valid} !== 3'b100) begin
         errors++; $display("FAIL flush_flags: got rdy/busy/vld=%b want 100", {ready, busy, valid});
      end
      checks++;
      if (result !== 32'd81) begin
         errors++; $display("FAIL flush_result_held: got %h want 00000051", result);
      end
      run_op(3'b000, 32'd3, 32'd4, lat, res);
      checks++;
      if (lat != 3) begin
         errors++; $display("FAIL flush_then_mul_lat: got %0d want 3", lat);
      end
      checks++;
      if (res !== 32'd12) begin
         errors++; $display("FAIL flush_then_mul_result: got %h want 0000000c", res);
      end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL flush_no_late_valid: got valid seen=%b want 0", seen);
      end
      funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (busy === 1'b1 || valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || result !== 32'd12) begin
         errors++; $display("FAIL flush_with_start: got activity=%b result=%h want 0 and 0000000c",
                            seen, result);
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready, busy, valid} !== 3'b100) begin
         errors++; $display("FAIL rst_mid_flags: got rdy/busy/vld=%b want 100", {ready, busy, valid});
      end
      checks++;
      if (result !== 32'h0) begin
         errors++; $display("FAIL rst_mid_result: got %h want 00000000", result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rst_mid_no_valid: got valid seen=%b want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int          lat;
      logic [31:0] res;
      run_op(3'b000, 32'd5, 32'd6, lat, res);
      checks++;
      if (lat != 3 || res !== 32'd30) begin
         errors++; $display("FAIL b2b_first: got lat=%0d res=%h want 3 and 0000001e", lat, res);
      end
      run_op(3'b000, 32'd7, 32'd8, lat, res);
      checks++;
      if (lat != 3) begin
         errors++; $display("FAIL b2b_second_lat: got %0d want 3", lat);
      end
      checks++;
      if (res !== 32'd56) begin
         errors++; $display("FAIL b2b_second_result: got %h want 00000038", res);
      end
      run_op(3'b101, 32'd9, 32'd0, lat, res);
      checks++;
      if (lat != 1 || res !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL b2b_special: got lat=%0d res=%h want 1 and ffffffff", lat, res);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_special();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle RV32M/RV64M execution unit in the execute stage, alongside the single-cycle ALU. It takes the M-extension funct3 directly and computes MUL/MULH/MULHSU/MULHU with a configurable-latency multiplier and DIV/DIVU/REM/REMU with an iterative radix-2 restoring divider. It includes RISC-V divide-by-zero and overflow semantics, and exposes a ready/start/valid handshake so the hazard unit can stall on `busy_o`.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `MUL_LAT`, 2: cycles spent in MUL state; 1..4.

- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: request; accepted on a rising edge when `ready_o`=1.
- `funct3_i`  in  3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a_i`  in  XLEN: rs1 / dividend.
- `op_b_i`  in  XLEN: rs2 / divisor.
- `flush_i`  in  1: abort current operation (pipeline flush).
- `ready_o`  out  1: unit can accept `start_i` this cycle.
- `busy_o`  out  1: operation in flight; stall request.
- `valid_o`  out  1: one-cycle pulse, `result_o` newly valid.
- `result_o`  out  XLEN: result; held until next completion.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- `ready_o` = IDLE or DONE. `busy_o` = MUL, DIV or FIX. `valid_o` = DONE.
- On accept, latch `funct3_i`, `op_a_i` and `op_b_i`. Inputs may change afterwards.
- funct3[2]=0 → MUL.
  - Stay `MUL_LAT` cycles, then go to DONE.
  - Full 2·XLEN product. MUL returns the low XLEN bits.
  - MULH returns the high half of signed×signed.
  - MULHSU returns the high half of signed a × unsigned b.
  - MULHU returns the high half of unsigned×unsigned.
- funct3[2]=1, divisor = 0 → DONE directly.
  - DIV/DIVU give all-ones.
  - REM/REMU give the dividend.
- funct3[2]=1, signed op, dividend = −2^(XLEN−1), divisor = −1 → DONE directly.
  - DIV gives the dividend.
  - REM gives 0.
- Otherwise → DIV.
  - Signed ops divide magnitudes.
  - One quotient bit per cycle, MSB first, for exactly XLEN cycles.
  - XLEN-bit iteration counter; the last iteration moves to FIX.
- FIX (1 cycle):
  - DIV negates the quotient if operand signs differ.
  - REM negates the remainder if the dividend is negative.
  - Unsigned ops pass through unchanged.
  - Then go to DONE.
- DONE:
  - `result_o` takes the final value on entry to DONE.
  - Next state is IDLE, or MUL/DIV/DONE if a new start is accepted (back-to-back issue).
- `flush_i`=1 in any state:
  - Next state IDLE; overrides a simultaneous `start_i`.
  - No `valid_o` for the aborted operation.
  - `result_o` unchanged.
- `start_i` while `ready_o`=0 is ignored. It is not queued.

## Timing
- Reset, asynchronous on `rst_n` low from any state:
  - State IDLE.
  - `result_o`=0, `valid_o`=0, `busy_o`=0, `ready_o`=1.
  - Counter and datapath registers cleared.
- Latency is the cycles from the accept edge to the cycle in which `valid_o`=1. The accept cycle is cycle 0.
  - Multiply: `MUL_LAT`+1.
  - Normal divide: XLEN+2.
  - Divide by zero / overflow: 1.
- `valid_o` is exactly one cycle wide, registered (no combinational path from inputs).
- `result_o` is registered; it changes only on the edge entering DONE.
- Back-to-back: a start accepted in DONE begins the next operation with the same latencies; `valid_o` deasserts on the following cycle.
- Reset mid-operation: immediate IDLE; no `valid_o` on release.

## Test plan
- XLEN=32, MUL_LAT=2; MUL 7 × 0xFFFFFFFD → `result_o`=0xFFFFFFEB, `valid_o` in cycle 3 only, `busy_o` high cycles 1–2.
- MULH, MULHU, MULHSU with a=b=0xFFFFFFFF → 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF respectively.
- DIV, then REM, with a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD, 0xFFFFFFFF; `valid_o` in cycle 34; DIVU 100/7 → 14, REMU → 2.
- Special cases, each with `valid_o` in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same → 0.
- Flush during DIV iteration 10 → no `valid_o`, `ready_o`=1 next cycle, `result_o` unchanged; an immediate MUL 3×4 → 12 in cycle 3; flush together with start in IDLE → start ignored.
- `rst_n` low mid-DIV, asynchronously between edges → outputs at reset values immediately; back-to-back MUL issued in DONE cycle → two `valid_o` pulses 3 cycles apart.
